// File: rtl/cpu_pkg.sv
// Shared fetch-pipeline types and constants: FSM encoding, PC read offsets,
// prefetch queue entry layout and the default reset vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_HOLD,
    FS_DRAIN
  } fetch_state_t;

  localparam logic [31:0] ARM_PC_OFFSET        = 32'd8;
  localparam logic [31:0] THUMB_PC_OFFSET      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } pq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_prefetch_queue.sv
// Prefetch FIFO of {addr, word} entries; head is visible combinationally, push lands next cycle.
// Push is dropped when full unless a pop frees the slot in the same cycle; clear wins over both.
module prefetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  pq_entry_t                push_data,
  input  logic                     pop,
  output pq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pq_entry_t       slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: one outstanding word read, prefetch queue, IR load and stage valids.
// THUMB_FETCH_EN adds the thumb_mode input for halfword fetch; default build is ARM-only.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          PQ_DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        exec_stall,
`ifdef THUMB_FETCH_EN
  input  logic        thumb_mode,
`endif
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ir_load,
  output logic [31:0] ir_data,
  output logic        decode_valid,
  output logic        execute_valid,
  output logic [31:0] r15_value
);
  localparam int CW = $clog2(PQ_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   next_pc;
  logic [31:0]   decode_addr;
  logic [31:0]   exec_addr;
  logic [31:0]   step;
  logic [31:0]   tgt_mask;
  logic [31:0]   pc_offset;
  logic          push;
  logic          pop;
  logic          advance;
  logic          pq_full;
  logic          pq_empty;
  logic [CW-1:0] pq_count;
  pq_entry_t     push_entry;
  pq_entry_t     head;

`ifdef THUMB_FETCH_EN
  // Instruction set only switches at a branch, when the queue is flushed anyway
  logic thumb_q;
  always_ff @(posedge clk) begin
    if (rst)               thumb_q <= 1'b0;
    else if (branch_valid) thumb_q <= thumb_mode;
  end
  assign step      = thumb_q ? 32'd2 : 32'd4;
  assign tgt_mask  = thumb_mode ? ~32'd1 : ~32'd3;
  assign pc_offset = thumb_q ? THUMB_PC_OFFSET : ARM_PC_OFFSET;
  assign ir_data   = thumb_q ? {16'h0000, head.addr[1] ? head.word[31:16] : head.word[15:0]}
                             : head.word;
`else
  assign step      = 32'd4;
  assign tgt_mask  = ~32'd3;
  assign pc_offset = ARM_PC_OFFSET;
  assign ir_data   = head.word;
`endif

  assign advance    = !decode_valid || !exec_stall;
  assign pop        = !pq_empty && advance && !branch_valid;
  assign push       = mem_req && mem_ack && (state == FS_REQ) && !branch_valid && (!pq_full || pop);
  assign push_entry = {pc, mem_rdata};
  assign ir_load    = pop;
  assign r15_value  = exec_addr + pc_offset;

  always_comb begin
    next_pc = pc;
    if (branch_valid) next_pc = branch_target & tgt_mask;
    else if (push)    next_pc = pc + step;
  end

  prefetch_queue #(.DEPTH(PQ_DEPTH)) u_pq (
    .clk       (clk),
    .rst       (rst),
    .clear     (branch_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (pq_count),
    .full      (pq_full),
    .empty     (pq_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FS_IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= word_align(RESET_VECTOR);
      pc            <= RESET_VECTOR;
      decode_valid  <= 1'b0;
      execute_valid <= 1'b0;
      decode_addr   <= RESET_VECTOR;
      exec_addr     <= RESET_VECTOR;
    end else begin
      pc <= next_pc;

      if (branch_valid) begin
        decode_valid  <= 1'b0;
        execute_valid <= 1'b0;
      end else if (advance) begin
        execute_valid <= decode_valid;
        exec_addr     <= decode_addr;
        decode_valid  <= pop;
        if (pop) decode_addr <= head.addr;
      end

      // mem_addr stays on the old word while draining; pc already points at the target
      if (branch_valid) begin
        if (mem_req && !mem_ack) begin
          state <= FS_DRAIN;
        end else begin
          state    <= FS_REQ;
          mem_req  <= 1'b1;
          mem_addr <= word_align(next_pc);
        end
      end else begin
        case (state)
          FS_IDLE: begin
            state    <= FS_REQ;
            mem_req  <= 1'b1;
            mem_addr <= word_align(next_pc);
          end
          FS_REQ: begin
            if (mem_ack) begin
              if (push && !pop && (pq_count == CW'(PQ_DEPTH - 1))) begin
                state   <= FS_HOLD;
                mem_req <= 1'b0;
              end else begin
                mem_addr <= word_align(next_pc);
              end
            end
          end
          FS_HOLD: begin
            if (pop) begin
              state    <= FS_REQ;
              mem_req  <= 1'b1;
              mem_addr <= word_align(next_pc);
            end
          end
          FS_DRAIN: begin
            if (mem_ack) begin
              state    <= FS_REQ;
              mem_addr <= word_align(next_pc);
            end
          end
          default: begin
            state   <= FS_IDLE;
            mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
